// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg
//   Shared types and helpers for the memory/writeback stage:
//   - wb_sel_e     : writeback source select (ALU, MEM, PC+4, CSR)
//   - F3_*         : func3 encodings for load/store size and sign
//   - lsu_state_e  : load/store FSM states (IDLE, WAIT, DONE)
//   - access_size  : classifies func3 as byte / half / word
//   - byte_enables : byte-lane enables for a store/load
//   - store_lanes  : replicates store data across the byte lanes
//   Lane helpers are fixed at 32 bits.
package mem_wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_CSR = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Undefined func3 codes (011, 110, 111) fall into the word class.
  function automatic logic [1:0] access_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: access_size = SZ_BYTE;
      F3_H, F3_HU: access_size = SZ_HALF;
      default:     access_size = SZ_WORD;
    endcase
  endfunction

  // Halfwords only look at a[1]; words ignore the low address bits.
  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] a);
    case (access_size(f3))
      SZ_BYTE: byte_enables = 4'b0001 << a;
      SZ_HALF: byte_enables = 4'b0011 << {a[1], 1'b0};
      default: byte_enables = 4'b1111;
    endcase
  endfunction

  // The bus picks the live lane with the byte enables, so the data is
  // simply copied into every lane it could land in.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (access_size(f3))
      SZ_BYTE: store_lanes = {4{d[7:0]}};
      SZ_HALF: store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_formatter.sv
// load_formatter
//   Combinational load-data alignment and extension.
//   Ports:
//     rdata   in  DW  raw word from the data bus
//     addr_lo in  2   low address bits selecting the byte/half lane
//     func3   in  3   access size/sign (LB/LH sign-extend, LBU/LHU zero-extend,
//                     LW and undefined codes pass the word through)
//     result  out DW  formatted load value
module load_formatter
  import mem_wb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rdata,
  input  logic [1:0]    addr_lo,
  input  logic [2:0]    func3,
  output logic [DW-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane first, then extend according to func3.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase

    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (func3)
      F3_B:    result = {{(DW-8){byte_sel[7]}}, byte_sel};
      F3_BU:   result = {{(DW-8){1'b0}}, byte_sel};
      F3_H:    result = {{(DW-16){half_sel[15]}}, half_sel};
      F3_HU:   result = {{(DW-16){1'b0}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   Memory/writeback pipeline stage. Runs loads and stores on a req/gnt/rvalid
//   data bus, formats load data, selects the writeback source and drives the
//   register-file write port. stall_o freezes the upstream pipeline registers
//   while an access is open, so the *_m inputs hold steady for its duration.
//   Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses are
//   suppressed and reported on misalign_o / misalign_addr_o). Without it the
//   low address bits are truncated and the misalign outputs are tied 0.
//   Ports:
//     clk_i, rst_i                 clock, synchronous active-high reset
//     alu_out_m, write_data_m      address/ALU result and store data
//     rd_m, pc_plus_4_m            destination register, link value
//     reg_write_m, wb_sel_m        writeback enable and source select
//     mem_write_m, func3_m         store flag, access size/sign
//     csr_rdata_i                  CSR read data for wb_sel 11
//     dbus_*                       data bus request / response
//     rf_we_o, rf_waddr_o, rf_wdata_o   register-file write port
//     stall_o                      upstream freeze
//     misalign_o, misalign_addr_o  misaligned-access report
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DW   = 32,
  parameter int REGW = $clog2(DW)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [DW-1:0]   alu_out_m,
  input  logic [DW-1:0]   write_data_m,
  input  logic [REGW-1:0] rd_m,
  input  logic [DW-1:0]   pc_plus_4_m,
  input  logic            reg_write_m,
  input  logic [1:0]      wb_sel_m,
  input  logic            mem_write_m,
  input  logic [2:0]      func3_m,
  input  logic [DW-1:0]   csr_rdata_i,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [DW-1:0]   dbus_addr_o,
  output logic [3:0]      dbus_be_o,
  output logic [DW-1:0]   dbus_wdata_o,
  input  logic            dbus_gnt_i,
  input  logic            dbus_rvalid_i,
  input  logic [DW-1:0]   dbus_rdata_i,
  output logic            rf_we_o,
  output logic [REGW-1:0] rf_waddr_o,
  output logic [DW-1:0]   rf_wdata_o,
  output logic            stall_o,
  output logic            misalign_o,
  output logic [DW-1:0]   misalign_addr_o
);

  lsu_state_e    state_q, state_d;
  logic [DW-1:0] load_q;
  logic [DW-1:0] load_fmt;
  logic [DW-1:0] wb_mux;
  logic          is_load, is_store, mem_op;
  logic          misaligned, access_ok;
  logic          in_idle, in_wait, in_done;

  assign is_load  = reg_write_m && (wb_sel_m == WB_MEM);
  assign is_store = mem_write_m;
  assign mem_op   = is_load || is_store;

`ifdef LSU_MISALIGN_TRAP_EN
  // A misaligned access never reaches the bus; it is reported for one cycle
  // instead and the instruction retires without a register write.
  always_comb begin
    misaligned = 1'b0;
    if (mem_op) begin
      case (access_size(func3_m))
        SZ_BYTE: misaligned = 1'b0;
        SZ_HALF: misaligned = alu_out_m[0];
        default: misaligned = (alu_out_m[1:0] != 2'b00);
      endcase
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  assign access_ok = mem_op && !misaligned;

  assign in_idle = (state_q == IDLE);
  assign in_wait = (state_q == WAIT);
  assign in_done = (state_q == DONE);

  load_formatter #(.DW(DW)) u_load_formatter (
    .rdata   (dbus_rdata_i),
    .addr_lo (alu_out_m[1:0]),
    .func3   (func3_m),
    .result  (load_fmt)
  );

  // Next-state logic. Stores finish once the bus grants; loads additionally
  // wait for rvalid. DONE always lasts exactly one cycle so the frozen
  // instruction can retire before the pipeline moves on.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (access_ok && dbus_gnt_i) state_d = is_store ? DONE : WAIT;
      WAIT: if (dbus_rvalid_i) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured load data. Reset abandons any open access, so a late
  // rvalid arriving afterwards lands in IDLE and is ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      if (in_wait && dbus_rvalid_i) load_q <= load_fmt;
    end
  end

  // Writeback source for single-cycle instructions.
  always_comb begin
    case (wb_sel_e'(wb_sel_m))
      WB_ALU:  wb_mux = alu_out_m;
      WB_MEM:  wb_mux = load_q;
      WB_PC4:  wb_mux = pc_plus_4_m;
      default: wb_mux = csr_rdata_i;
    endcase
  end

  // Output decode. Everything is forced low while reset is held.
  always_comb begin
    dbus_req_o      = 1'b0;
    dbus_we_o       = 1'b0;
    dbus_addr_o     = '0;
    dbus_be_o       = '0;
    dbus_wdata_o    = '0;
    rf_we_o         = 1'b0;
    rf_waddr_o      = '0;
    rf_wdata_o      = '0;
    stall_o         = 1'b0;
    misalign_o      = 1'b0;
    misalign_addr_o = '0;
    if (!rst_i) begin
      dbus_req_o   = in_idle && access_ok;
      dbus_we_o    = is_store;
      dbus_addr_o  = {alu_out_m[DW-1:2], 2'b00};
      dbus_be_o    = byte_enables(func3_m, alu_out_m[1:0]);
      dbus_wdata_o = store_lanes(func3_m, write_data_m);
      stall_o      = (in_idle && access_ok) || in_wait;
      rf_we_o      = ((in_idle && !mem_op && reg_write_m) || (in_done && is_load))
                     && (rd_m != '0);
      rf_waddr_o   = rd_m;
      rf_wdata_o   = in_done ? load_q : wb_mux;
      misalign_o   = in_idle && misaligned;
      if (misalign_o) misalign_addr_o = alu_out_m;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
//   Self-checking bench for mem_wb_stage: a table of single-cycle writeback
//   vectors, hand-written access sequences for the multi-cycle corners, and a
//   randomized run compared against a byte-level reference model.
module tb_mem_wb_stage;
  import mem_wb_pkg::*;

  localparam int DW   = 32;
  localparam int REGW = 5;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [DW-1:0]   alu_out_m, write_data_m, pc_plus_4_m, csr_rdata_i;
  logic [REGW-1:0] rd_m;
  logic            reg_write_m, mem_write_m;
  logic [1:0]      wb_sel_m;
  logic [2:0]      func3_m;
  logic            dbus_req_o, dbus_we_o, dbus_gnt_i, dbus_rvalid_i;
  logic [DW-1:0]   dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
  logic [3:0]      dbus_be_o;
  logic            rf_we_o, stall_o, misalign_o;
  logic [REGW-1:0] rf_waddr_o;
  logic [DW-1:0]   rf_wdata_o, misalign_addr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mem_wb_stage #(.DW(DW), .REGW(REGW)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .alu_out_m       (alu_out_m),
    .write_data_m    (write_data_m),
    .rd_m            (rd_m),
    .pc_plus_4_m     (pc_plus_4_m),
    .reg_write_m     (reg_write_m),
    .wb_sel_m        (wb_sel_m),
    .mem_write_m     (mem_write_m),
    .func3_m         (func3_m),
    .csr_rdata_i     (csr_rdata_i),
    .dbus_req_o      (dbus_req_o),
    .dbus_we_o       (dbus_we_o),
    .dbus_addr_o     (dbus_addr_o),
    .dbus_be_o       (dbus_be_o),
    .dbus_wdata_o    (dbus_wdata_o),
    .dbus_gnt_i      (dbus_gnt_i),
    .dbus_rvalid_i   (dbus_rvalid_i),
    .dbus_rdata_i    (dbus_rdata_i),
    .rf_we_o         (rf_we_o),
    .rf_waddr_o      (rf_waddr_o),
    .rf_wdata_o      (rf_wdata_o),
    .stall_o         (stall_o),
    .misalign_o      (misalign_o),
    .misalign_addr_o (misalign_addr_o)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  wb;
    logic [4:0]  rd;
    logic [31:0] alu, pc4, csr;
    logic        exp_we;
    logic        chk_data;
    logic [31:0] exp_wdata;
  } vec_t;

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic int nbytes(input logic [2:0] f3);
    if (f3 == F3_B || f3 == F3_BU) return 1;
    if (f3 == F3_H || f3 == F3_HU) return 2;
    return 4;
  endfunction

  function automatic int lane_off(input logic [31:0] a, input logic [2:0] f3);
    int n = nbytes(f3);
    return ((a % 4) / n) * n;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] a, input logic [2:0] f3);
    int n = nbytes(f3);
    return 4'(((1 << n) - 1) << lane_off(a, f3));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [2:0] f3);
    logic [31:0] r;
    int n = nbytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [2:0] f3);
    logic [31:0] mask, v;
    int n = nbytes(f3);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
    v = (rd >> (8 * lane_off(a, f3))) & mask;
    if (n < 4 && !f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- helpers ----------------
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic applyStimulus(input logic rw, input logic [1:0] wb, input logic [4:0] rd,
                               input logic [31:0] alu, input logic [31:0] wd,
                               input logic [31:0] pc4, input logic mw,
                               input logic [2:0] f3, input logic [31:0] csr);
    reg_write_m   = rw;
    wb_sel_m      = wb;
    rd_m          = rd;
    alu_out_m     = alu;
    write_data_m  = wd;
    pc_plus_4_m   = pc4;
    mem_write_m   = mw;
    func3_m       = f3;
    csr_rdata_i   = csr;
    dbus_gnt_i    = 1'b0;
    dbus_rvalid_i = 1'b0;
    dbus_rdata_i  = $urandom;
  endtask

  task automatic applyNop();
    applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000, 32'h0);
  endtask

  // Single-cycle instruction: writes back in the same cycle, never stalls.
  task automatic run_alu(input logic rw, input logic [1:0] wb, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] csr);
    logic [31:0] exp_d;
    applyStimulus(rw, wb, rd, alu, $urandom, pc4, 1'b0, 3'($urandom_range(0, 7)), csr);
    exp_d = (wb == 2'b00) ? alu : (wb == 2'b10) ? pc4 : csr;
    settle();
    checkOutput("alu_stall", 32'(stall_o), 32'd0);
    checkOutput("alu_req", 32'(dbus_req_o), 32'd0);
    checkOutput("alu_we", 32'(rf_we_o), 32'(rw && rd != 0));
    checkOutput("alu_waddr", 32'(rf_waddr_o), 32'(rd));
    checkOutput("alu_wdata", rf_wdata_o, exp_d);
    tick();
  endtask

  // Full bus access: g idle cycles before gnt, r cycles in WAIT before rvalid.
  task automatic run_mem(input logic st, input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3,
                         input int g, input int r, input logic [31:0] rdat);
    applyStimulus(!st, st ? 2'b00 : 2'b01, rd, a, wd, $urandom, st, f3, $urandom);
    for (int k = 0; k <= g; k++) begin
      dbus_gnt_i    = (k == g);
      dbus_rvalid_i = 1'b0;
      settle();
      checkOutput("req_req", 32'(dbus_req_o), 32'd1);
      checkOutput("req_stall", 32'(stall_o), 32'd1);
      checkOutput("req_rfwe", 32'(rf_we_o), 32'd0);
      checkOutput("req_we", 32'(dbus_we_o), 32'(st));
      checkOutput("req_addr", dbus_addr_o, a & 32'hFFFF_FFFC);
      checkOutput("req_be", 32'(dbus_be_o), 32'(model_be(a, f3)));
      if (st) checkOutput("req_wdata", dbus_wdata_o, model_wdata(wd, f3));
      checkOutput("req_misalign", 32'(misalign_o), 32'd0);
      tick();
    end
    if (!st) begin
      for (int k = 0; k <= r; k++) begin
        dbus_gnt_i    = 1'($urandom);
        dbus_rvalid_i = (k == r);
        dbus_rdata_i  = (k == r) ? rdat : $urandom;
        settle();
        checkOutput("wait_req", 32'(dbus_req_o), 32'd0);
        checkOutput("wait_stall", 32'(stall_o), 32'd1);
        checkOutput("wait_rfwe", 32'(rf_we_o), 32'd0);
        tick();
      end
    end
    dbus_gnt_i    = 1'b0;
    dbus_rvalid_i = 1'($urandom);
    dbus_rdata_i  = $urandom;
    settle();
    checkOutput("done_stall", 32'(stall_o), 32'd0);
    checkOutput("done_req", 32'(dbus_req_o), 32'd0);
    checkOutput("done_rfwe", 32'(rf_we_o), 32'(!st && rd != 0));
    if (!st) begin
      checkOutput("done_waddr", 32'(rf_waddr_o), 32'(rd));
      checkOutput("done_wdata", rf_wdata_o, model_load(rdat, a, f3));
    end
    tick();
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 2'b00, 5'd5,  32'h0000_1234, 32'h0000_2000, 32'h00C0_FFEE, 1'b1, 1'b1, 32'h0000_1234};
    vecs[1] = '{1'b1, 2'b10, 5'd1,  32'h0000_DEAD, 32'h0000_0104, 32'h0000_0055, 1'b1, 1'b1, 32'h0000_0104};
    vecs[2] = '{1'b1, 2'b11, 5'd31, 32'h0000_0001, 32'h0000_0008, 32'hCAFE_BABE, 1'b1, 1'b1, 32'hCAFE_BABE};
    vecs[3] = '{1'b1, 2'b00, 5'd0,  32'h0000_0077, 32'h0000_0010, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0077};
    vecs[4] = '{1'b0, 2'b00, 5'd7,  32'h0000_0099, 32'h0000_0020, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0099};
    vecs[5] = '{1'b0, 2'b01, 5'd3,  32'h0000_0500, 32'h0000_0030, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000};

    // Reset with a load presented: every control output must stay low.
    rst_i = 1'b1;
    applyStimulus(1'b1, 2'b01, 5'd4, 32'h100, 32'h0, 32'h0, 1'b0, F3_W, 32'h0);
    dbus_gnt_i = 1'b1;
    tick();
    settle();
    checkOutput("rst_req", 32'(dbus_req_o), 32'd0);
    checkOutput("rst_stall", 32'(stall_o), 32'd0);
    checkOutput("rst_rfwe", 32'(rf_we_o), 32'd0);
    checkOutput("rst_misalign", 32'(misalign_o), 32'd0);
    tick();
    rst_i = 1'b0;
    applyNop();
    settle();
    checkOutput("post_rst_stall", 32'(stall_o), 32'd0);
    tick();

    // Table of single-cycle writeback vectors.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].rw, vecs[i].wb, vecs[i].rd, vecs[i].alu, 32'h0, vecs[i].pc4,
                    1'b0, F3_W, vecs[i].csr);
      settle();
      checkOutput($sformatf("vec%0d_we", i), 32'(rf_we_o), 32'(vecs[i].exp_we));
      checkOutput($sformatf("vec%0d_stall", i), 32'(stall_o), 32'd0);
      checkOutput($sformatf("vec%0d_req", i), 32'(dbus_req_o), 32'd0);
      if (vecs[i].exp_we) checkOutput($sformatf("vec%0d_waddr", i), 32'(rf_waddr_o), 32'(vecs[i].rd));
      if (vecs[i].chk_data) checkOutput($sformatf("vec%0d_wdata", i), rf_wdata_o, vecs[i].exp_wdata);
      tick();
    end

    // SB to byte 3, granted immediately.
    run_mem(1'b1, 5'd0, 32'h0000_0103, 32'h0000_00AB, F3_B, 0, 0, 32'h0);
    // LB from byte 2 with a two-cycle grant delay, rvalid one cycle later.
    run_mem(1'b0, 5'd6, 32'h0000_0102, 32'h0, F3_B, 2, 0, 32'h0080_0000);
    // LHU upper half into x0: data formatted but never written.
    run_mem(1'b0, 5'd0, 32'h0000_0102, 32'h0, F3_HU, 0, 1, 32'h8001_0000);

    // Reset while waiting for load data, then a late rvalid.
    applyStimulus(1'b1, 2'b01, 5'd9, 32'h200, 32'h0, 32'h0, 1'b0, F3_W, 32'h0);
    dbus_gnt_i = 1'b1;
    settle();
    checkOutput("r5_req", 32'(dbus_req_o), 32'd1);
    tick();
    dbus_gnt_i = 1'b0;
    rst_i = 1'b1;
    settle();
    checkOutput("r5_rst_stall", 32'(stall_o), 32'd0);
    checkOutput("r5_rst_rfwe", 32'(rf_we_o), 32'd0);
    tick();
    rst_i = 1'b0;
    applyNop();
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = 32'h1234_5678;
    settle();
    checkOutput("r5_late_stall", 32'(stall_o), 32'd0);
    checkOutput("r5_late_rfwe", 32'(rf_we_o), 32'd0);
    tick();
    dbus_rvalid_i = 1'b0;
    settle();
    checkOutput("r5_idle_stall", 32'(stall_o), 32'd0);
    checkOutput("r5_idle_rfwe", 32'(rf_we_o), 32'd0);
    tick();
    run_alu(1'b1, 2'b00, 5'd8, 32'h0000_0ACE, 32'h0, 32'h0);

    // Misaligned LW.
`ifdef LSU_MISALIGN_TRAP_EN
    applyStimulus(1'b1, 2'b01, 5'd4, 32'h0000_0101, 32'h0, 32'h0, 1'b0, F3_W, 32'h0);
    dbus_gnt_i = 1'b1;
    settle();
    checkOutput("mis_flag", 32'(misalign_o), 32'd1);
    checkOutput("mis_addr", misalign_addr_o, 32'h0000_0101);
    checkOutput("mis_req", 32'(dbus_req_o), 32'd0);
    checkOutput("mis_stall", 32'(stall_o), 32'd0);
    checkOutput("mis_rfwe", 32'(rf_we_o), 32'd0);
    tick();
    applyNop();
    settle();
    checkOutput("mis_after_stall", 32'(stall_o), 32'd0);
    tick();
`else
    run_mem(1'b0, 5'd4, 32'h0000_0101, 32'h0, F3_W, 0, 0, 32'hA5A5_1234);
`endif

    // Randomized mix of ALU, load and store instructions.
    for (int t = 0; t < 200; t++) begin
      int kind;
      logic [2:0]  f3;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      f3   = 3'($urandom_range(0, 7));
      a    = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
      a = a & ~32'(nbytes(f3) - 1);
`endif
      if (kind == 0) begin
        logic [1:0] wb;
        wb = 2'($urandom_range(0, 3));
        if (wb == 2'b01) wb = 2'b10;
        run_alu(1'($urandom), wb, 5'($urandom), $urandom, $urandom, $urandom);
      end else begin
        run_mem(kind == 1, 5'($urandom), a, $urandom, f3,
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
